// File: rtl/rptr_handler_gen2_pkg.sv
// Pointer helpers shared by the read- and write-side FIFO pointer handlers.
// Functions work on a fixed-width word; callers zero-extend in and truncate out.
package rptr_handler_gen2_pkg;

    localparam int PTR_MAX_W = 16;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Zero-extended upper bits leave the low-order conversion unchanged.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return (b >> 1) ^ b;
    endfunction

endpackage

// File: rtl/rptr_handler_gen2_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module gray_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rptr_handler_gen2.sv
// Read-side pointer handler for an async FIFO: synchronizes the write pointer,
// advances the read pointer, and produces registered empty / level / underflow status.
module rptr_handler_gen2
    import rptr_handler_gen2_pkg::*;
#(
    parameter int PTR_WIDTH   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic               rd_clk,
    input  logic               rd_rst_n,
    input  logic               rd_en_i,
    input  logic               rd_flush_i,
    input  logic [PTR_WIDTH:0] g_wptr_i,
    output logic [PTR_WIDTH:0] b_rptr_o,
    output logic [PTR_WIDTH:0] g_rptr_o,
    output logic               empty_o,
    output logic               almost_empty_o,
    output logic [PTR_WIDTH:0] rd_level_o,
    output logic               underflow_o
);

    localparam int PW1 = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] AE_LIMIT = PW1'(AE_THRESH);

    logic [PTR_WIDTH:0] g_wptr_sync;
    logic [PTR_WIDTH:0] wptr_bin_sync;
    logic               rd_acc;
    logic [PTR_WIDTH:0] b_rptr_next;
    logic [PTR_WIDTH:0] g_rptr_next;
    logic [PTR_WIDTH:0] level_next;
    logic               empty_next;
    logic               almost_empty_next;
    logic               underflow_next;

    gray_sync #(
        .WIDTH  (PW1),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (rd_clk),
        .rst_n (rd_rst_n),
        .d_i   (g_wptr_i),
        .q_o   (g_wptr_sync)
    );

    assign wptr_bin_sync = PW1'(gray2bin(ptr_word_t'(g_wptr_sync)));

    // Flush jumps the read pointer onto the synchronized write pointer and wins over reads.
    always_comb begin
        rd_acc            = rd_en_i & ~empty_o & ~rd_flush_i;
        b_rptr_next       = rd_flush_i ? wptr_bin_sync : b_rptr_o + PW1'(rd_acc);
        g_rptr_next       = PW1'(bin2gray(ptr_word_t'(b_rptr_next)));
        level_next        = wptr_bin_sync - b_rptr_next;
        empty_next        = (g_rptr_next == g_wptr_sync);
        almost_empty_next = (level_next <= AE_LIMIT);
        underflow_next    = rd_en_i & empty_o & ~rd_flush_i;
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            b_rptr_o       <= '0;
            g_rptr_o       <= '0;
            empty_o        <= 1'b1;
            almost_empty_o <= 1'b1;
            rd_level_o     <= '0;
            underflow_o    <= 1'b0;
        end else begin
            b_rptr_o       <= b_rptr_next;
            g_rptr_o       <= g_rptr_next;
            empty_o        <= empty_next;
            almost_empty_o <= almost_empty_next;
            rd_level_o     <= level_next;
            underflow_o    <= underflow_next;
        end
    end

endmodule
